// File: rtl/xr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : xr_mem_pkg
//  Purpose  : Shared types and constants for the instruction/data memory
//             arbiter (FSM states, latched request copy, fetch byte enable).
//  Revision : 1.0  initial release
// ============================================================================
package xr_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_REQ  = 3'd1,
        F_WAIT = 3'd2,
        D_REQ  = 3'd3,
        D_WAIT = 3'd4
    } mem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Memory is word addressed; the byte offset is always cleared.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Interface : mem_arb_if
//  Purpose   : Fetch, load/store and memory-side signals of the arbiter.
//              'master' is the arbiter's own view, 'slave' the environment's.
//  Revision  : 1.0  initial release
// ============================================================================
interface mem_arb_if;

    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_data;
    logic        if_err;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_rdy, if_data, if_err, ls_done, ls_rdata, ls_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_rdy, if_data, if_err, ls_done, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface
`default_nettype wire

// File: rtl/mem_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wdog
//  Purpose  : Per-access watchdog. Saturating cycle counter; expired_o is
//             raised in the cycle the count reaches TIMEOUT, so an access may
//             stay outstanding for at most TIMEOUT cycles.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wdog #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rstb,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Count active cycles of the current access, holding at TIMEOUT.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // This cycle is the TIMEOUT-th one of the access.
    assign expired_o = en_i && (cnt_q >= CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb
//  Purpose  : Shares one single-port memory between instruction fetch and
//             the load/store unit. One access outstanding at a time, with
//             alternating priority on contention, watchdog abort and fetch
//             discard on pipeline redirect.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb
    import xr_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic  clk,
    input  wire logic  rstb,
    mem_arb_if.master  bus
);

    mem_state_e  state_q;
    mem_req_t    req_q;
    logic        last_data_q;
    logic        discard_q;
    logic        if_rdy_q, if_err_q, ls_done_q, ls_err_q;
    logic [31:0] if_data_q, ls_rdata_q;

    logic w_busy, w_expired, w_fetch_ok, w_pick_data, w_pick_fetch, w_drop_fetch;

    assign w_busy       = (state_q != IDLE);
    // A redirect in the same cycle as the response still kills it.
    assign w_drop_fetch = discard_q | bus.flush;

    // Arbitration: data wins a tie unless the previous grant went to data.
    assign w_fetch_ok   = bus.if_req & ~bus.flush;
    assign w_pick_data  = bus.ls_req & ~(w_fetch_ok & last_data_q);
    assign w_pick_fetch = w_fetch_ok & ~w_pick_data;

    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .rstb      (rstb),
        .clr_i     (~w_busy),
        .en_i      (w_busy),
        .expired_o (w_expired)
    );

    // Access sequencer: arbitration, request latch, completion/abort results.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            req_q       <= '0;
            last_data_q <= 1'b0;
            discard_q   <= 1'b0;
            if_rdy_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_data_q   <= '0;
            ls_done_q   <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            if_rdy_q  <= 1'b0;
            if_err_q  <= 1'b0;
            ls_done_q <= 1'b0;
            ls_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Requesters drop their level in the pulse cycle; skip it.
                    if (!ls_done_q && !if_rdy_q) begin
                        if (w_pick_data) begin
                            req_q       <= '{we: bus.ls_we, addr: word_addr(bus.ls_addr),
                                             wdata: bus.ls_wdata, be: bus.ls_be};
                            last_data_q <= 1'b1;
                            state_q     <= D_REQ;
                        end else if (w_pick_fetch) begin
                            req_q       <= '{we: 1'b0, addr: word_addr(bus.if_addr),
                                             wdata: 32'h0, be: BE_WORD};
                            last_data_q <= 1'b0;
                            state_q     <= F_REQ;
                        end
                    end
                end
                F_REQ, F_WAIT: begin
                    if (bus.flush) begin
                        discard_q <= 1'b1;
                    end
                    if (state_q == F_WAIT && bus.mem_rvalid) begin
                        state_q   <= IDLE;
                        discard_q <= 1'b0;
                        if (!w_drop_fetch) begin
                            if_rdy_q  <= 1'b1;
                            if_data_q <= bus.mem_rdata;
                        end
                    end else if (w_expired) begin
                        state_q   <= IDLE;
                        discard_q <= 1'b0;
                        if (!w_drop_fetch) begin
                            if_rdy_q  <= 1'b1;
                            if_err_q  <= 1'b1;
                            if_data_q <= '0;
                        end
                    end else if (state_q == F_REQ && bus.mem_gnt) begin
                        state_q <= F_WAIT;
                    end
                end
                D_REQ, D_WAIT: begin
                    if (state_q == D_WAIT && bus.mem_rvalid) begin
                        state_q    <= IDLE;
                        ls_done_q  <= 1'b1;
                        ls_rdata_q <= req_q.we ? 32'h0 : bus.mem_rdata;
                    end else if (w_expired) begin
                        state_q    <= IDLE;
                        ls_done_q  <= 1'b1;
                        ls_err_q   <= 1'b1;
                        ls_rdata_q <= '0;
                    end else if (state_q == D_REQ && bus.mem_gnt) begin
                        state_q <= D_WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = (state_q == F_REQ) || (state_q == D_REQ);
    assign bus.mem_we    = req_q.we;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_be    = req_q.be;

    assign bus.if_rdy    = if_rdy_q;
    assign bus.if_data   = if_data_q;
    assign bus.if_err    = if_err_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arb
//  Purpose  : Directed self-checking bench for mem_arb (TIMEOUT=8) with a
//             small reactive memory model (configurable gnt/rvalid delays).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arb;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if bus();

    mem_arb #(.TIMEOUT(8)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Memory model configuration and state
    int          gnt_dly   = 0;
    int          rv_dly    = 1;
    bit          gnt_never = 1'b0;
    int          gwait     = 0;
    int          rcnt      = 0;
    bit          pend      = 1'b0;
    logic [31:0] gaddr     = '0;
    logic [31:0] g_addr[$];
    logic [3:0]  g_be[$];

    // Scratch used by the directed sequences
    int nd, nf, npulse, reqcyc, rv_cyc, done_cyc;
    bit seen, stable;
    logic [31:0] first_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Memory: gnt after gnt_dly waiting cycles, rvalid rv_dly cycles after gnt.
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (pend) begin
                if (rcnt <= 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = (gaddr == 32'h100) ? 32'hDEAD_BEEF : ~gaddr;
                    pend           = 1'b0;
                end else begin
                    rcnt--;
                end
            end else if (bus.mem_req && !gnt_never) begin
                if (gwait >= gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    gwait       = 0;
                    pend        = 1'b1;
                    rcnt        = rv_dly - 1;
                    gaddr       = bus.mem_addr;
                    g_addr.push_back(bus.mem_addr);
                    g_be.push_back(bus.mem_be);
                end else begin
                    gwait++;
                end
            end else begin
                gwait = 0;
            end
        end
    end

    initial begin
        bus.flush    = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        bus.ls_be    = 4'h0;

        // ---- Reset state
        repeat (3) tick();
        check_eq("rst_mem_req",  32'(bus.mem_req),  0);
        check_eq("rst_mem_addr", bus.mem_addr,      0);
        check_eq("rst_ls_done",  32'(bus.ls_done),  0);
        check_eq("rst_if_rdy",   32'(bus.if_rdy),   0);
        check_eq("rst_mem_be",   32'(bus.mem_be),   0);
        rstb = 1'b1;
        tick();

        // ---- Contention: grants alternate D,F,D,F
        nd = 0; nf = 0;
        bus.ls_addr = 32'h200; bus.ls_we = 1'b0; bus.ls_be = 4'h3;
        bus.if_addr = 32'h300;
        bus.ls_req  = 1'b1; bus.if_req = 1'b1;
        for (int i = 0; i < 80 && (nd < 2 || nf < 2); i++) begin
            tick();
            if (bus.ls_done) begin nd++; bus.ls_req = 1'b0; end
            else bus.ls_req = (nd < 2);
            if (bus.if_rdy) begin
                nf++;
                bus.if_req = 1'b0;
                check_eq("alt_if_data", bus.if_data, 32'hFFFF_FCFF);
            end else bus.if_req = (nf < 2);
        end
        bus.ls_req = 1'b0; bus.if_req = 1'b0;
        check_eq("alt_grants", 32'(g_addr.size()), 4);
        if (g_addr.size() == 4) begin
            check_eq("alt_g0_addr", g_addr[0], 32'h200);
            check_eq("alt_g1_addr", g_addr[1], 32'h300);
            check_eq("alt_g2_addr", g_addr[2], 32'h200);
            check_eq("alt_g3_addr", g_addr[3], 32'h300);
            check_eq("alt_g1_be",   32'(g_be[1]), 32'hF);
            check_eq("alt_g3_be",   32'(g_be[3]), 32'hF);
            check_eq("alt_g0_be",   32'(g_be[0]), 32'h3);
        end
        repeat (2) tick();

        // ---- Single load, minimum latency
        bus.ls_addr = 32'h103; bus.ls_we = 1'b0; bus.ls_be = 4'hF;
        bus.ls_req  = 1'b1;
        tick();
        check_eq("ld_mem_req",  32'(bus.mem_req), 1);
        check_eq("ld_mem_addr", bus.mem_addr,     32'h100);
        check_eq("ld_mem_we",   32'(bus.mem_we),  0);
        tick();
        check_eq("ld_n2_done",  32'(bus.ls_done), 0);
        tick();
        check_eq("ld_n3_done",  32'(bus.ls_done), 1);
        check_eq("ld_rdata",    bus.ls_rdata,     32'hDEAD_BEEF);
        check_eq("ld_err",      32'(bus.ls_err),  0);
        bus.ls_req = 1'b0;
        tick();
        check_eq("ld_pulse_end", 32'(bus.ls_done), 0);
        tick();

        // ---- Flush during F_WAIT discards the fetch, next fetch normal
        rv_dly = 2;
        bus.if_addr = 32'h40; bus.if_req = 1'b1;
        tick();                          // F_REQ, granted
        tick();                          // F_WAIT
        bus.flush = 1'b1; bus.if_addr = 32'h80;
        tick();
        bus.flush = 1'b0; rv_dly = 1;
        npulse = 0; first_data = '0;
        for (int i = 0; i < 20 && npulse == 0; i++) begin
            if (bus.if_rdy) begin
                npulse++;
                first_data = bus.if_data;
                bus.if_req = 1'b0;
            end
            if (npulse == 0) tick();
        end
        check_eq("fl_pulses",  32'(npulse), 1);
        check_eq("fl_if_data", first_data,  32'hFFFF_FF7F);
        check_eq("fl_if_err",  32'(bus.if_err), 0);
        bus.if_req = 1'b0;
        repeat (2) tick();

        // ---- Watchdog: store, gnt never comes
        gnt_never = 1'b1;
        bus.ls_addr = 32'h10; bus.ls_we = 1'b1; bus.ls_wdata = 32'h1234_5678; bus.ls_be = 4'hF;
        bus.ls_req = 1'b1;
        reqcyc = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (bus.mem_req) reqcyc++;
            if (bus.ls_done) seen = 1'b1;
        end
        check_eq("wd_done",     32'(seen),          1);
        check_eq("wd_req_cyc",  32'(reqcyc),        8);
        check_eq("wd_err",      32'(bus.ls_err),    1);
        check_eq("wd_rdata",    bus.ls_rdata,       0);
        check_eq("wd_req_drop", 32'(bus.mem_req),   0);
        bus.ls_req = 1'b0; gnt_never = 1'b0;
        repeat (2) tick();

        // ---- Reset during D_WAIT, late rvalid ignored
        rv_dly = 4;
        bus.ls_addr = 32'h100; bus.ls_we = 1'b0; bus.ls_req = 1'b1;
        tick();                          // D_REQ, granted
        tick();                          // D_WAIT
        rstb = 1'b0; bus.ls_req = 1'b0;
        #1;
        check_eq("rr_mem_req",  32'(bus.mem_req),  0);
        check_eq("rr_mem_addr", bus.mem_addr,      0);
        check_eq("rr_rdata",    bus.ls_rdata,      0);
        tick();
        tick();
        rstb = 1'b1;
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ls_done || bus.mem_req) npulse++;
        end
        check_eq("rr_no_activity", 32'(npulse), 0);
        rv_dly = 1;
        bus.ls_addr = 32'h104; bus.ls_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.ls_done) seen = 1'b1;
        end
        check_eq("rr_next_done",  32'(seen),       1);
        check_eq("rr_next_rdata", bus.ls_rdata,    32'hFFFF_FEFB);
        bus.ls_req = 1'b0;
        repeat (2) tick();

        // ---- Delayed gnt: request stable, done one cycle after rvalid
        gnt_dly = 3;
        bus.ls_addr = 32'h22; bus.ls_we = 1'b1; bus.ls_wdata = 32'hCAFE_F00D; bus.ls_be = 4'h6;
        bus.ls_req = 1'b1;
        reqcyc = 0; stable = 1'b1; rv_cyc = -100; done_cyc = -1; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (bus.mem_req) begin
                reqcyc++;
                if (bus.mem_addr !== 32'h20 || bus.mem_we !== 1'b1 ||
                    bus.mem_wdata !== 32'hCAFE_F00D || bus.mem_be !== 4'h6) stable = 1'b0;
            end
            if (bus.mem_rvalid) rv_cyc = cyc;
            if (bus.ls_done) begin seen = 1'b1; done_cyc = cyc; end
        end
        check_eq("dg_done",      32'(seen),              1);
        check_eq("dg_req_cyc",   32'(reqcyc),            4);
        check_eq("dg_stable",    32'(stable),            1);
        check_eq("dg_latency",   32'(done_cyc - rv_cyc), 1);
        check_eq("dg_st_rdata",  bus.ls_rdata,           0);
        bus.ls_req = 1'b0;
        gnt_dly = 0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
